// File: rtl/spi_slave_regfile_pkg.sv
// ---------------------------------------------------------------------------
// spi_slave_regfile_pkg
// Shared definitions for the SPI responder register file:
//   - FSM state encoding (S_IDLE .. S_WAIT)
//   - header lengths for 1-byte and 2-byte address modes
//   - encoding of the read/write header bit
//   - helper returning the bit-counter value of the last header bit
// ---------------------------------------------------------------------------
package spi_slave_regfile_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_WDATA = 3'd2,
        S_RDATA = 3'd3,
        S_WAIT  = 3'd4
    } spi_state_t;

    localparam int   HDR_BITS_1B = 8;
    localparam int   HDR_BITS_2B = 16;
    localparam logic SPI_RW_READ = 1'b1;

    // Bit counter value at which the final header bit is sampled.
    function automatic logic [3:0] hdr_last_bit(input logic two_byte);
        return two_byte ? 4'(HDR_BITS_2B - 1) : 4'(HDR_BITS_1B - 1);
    endfunction

endpackage

// File: rtl/spi_slave_regfile_pin_sync.sv
// ---------------------------------------------------------------------------
// spi_pin_sync
// Two-flop synchroniser for one asynchronous SPI pin, followed by an edge
// detector on the synchronised level.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset (all flops to 0)
//   i_pin    in   raw asynchronous pin
//   o_level  out  synchronised pin level
//   o_rise   out  1-clk strobe on a synchronised 0->1 transition
//   o_fall   out  1-clk strobe on a synchronised 1->0 transition
// ---------------------------------------------------------------------------
module spi_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Resetting to 0 means a chip enable held low across reset never
    // produces a falling edge, so no half-frame is started after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/spi_slave_regfile.sv
// ---------------------------------------------------------------------------
// spi_slave_regfile
// CPOL=0/CPHA=0, MSB-first SPI slave (3- or 4-wire) in front of an 8-bit
// register bank. All SPI pins are oversampled in the clk domain.
// Frame: header {rw, addr} (8 or 16 bits), then 8 data bits. Writes commit
// on the 8th data rise; reads shift out on falling edges.
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   three_wire    1: read data on spi_sdio, 0: read data on spi_sdo
//   addr_2byte    1: 16-bit header, 0: 8-bit header (latched at frame start)
//   status_in     value returned when STATUS_ADDR is read
//   host_addr     fabric read address; host_data = bank[host_addr], 1 clk later
//   wr_strobe     1-clk pulse per committed (or discarded) SPI write
//   wr_addr       address of the last SPI write
//   wr_data       data of the last SPI write
//   frame_err     1-clk pulse when chip enable rises mid-frame
//   spi_ce        chip enable, active low
//   spi_sclk      serial clock
//   spi_sdio      MOSI; also read-data out in 3-wire mode
//   spi_sdo       read-data out in 4-wire mode, released otherwise
// ---------------------------------------------------------------------------
module spi_slave_regfile
    import spi_slave_regfile_pkg::*;
#(
    parameter int          DEPTH       = 32,
    parameter logic [15:0] STATUS_ADDR = 16'h001F,
    parameter logic [7:0]  RST_VAL     = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        three_wire,
    input  logic        addr_2byte,
    input  logic [7:0]  status_in,
    input  logic [7:0]  host_addr,
    output logic [7:0]  host_data,
    output logic        wr_strobe,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        frame_err,
    input  logic        spi_ce,
    input  logic        spi_sclk,
    inout  wire         spi_sdio,
    output logic        spi_sdo
);

    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    logic w_ce, w_ce_fall, w_ce_rise;
    logic w_sclk, w_sclk_rise, w_sclk_fall;
    logic w_sdio, w_sdio_rise, w_sdio_fall;
    logic [2:0] w_unused_edges;

    spi_pin_sync u_sync_ce (
        .clk(clk), .rst(rst), .i_pin(spi_ce),
        .o_level(w_ce), .o_rise(w_ce_rise), .o_fall(w_ce_fall)
    );
    spi_pin_sync u_sync_sclk (
        .clk(clk), .rst(rst), .i_pin(spi_sclk),
        .o_level(w_sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_pin_sync u_sync_sdio (
        .clk(clk), .rst(rst), .i_pin(spi_sdio),
        .o_level(w_sdio), .o_rise(w_sdio_rise), .o_fall(w_sdio_fall)
    );

    // Chip enable is acted on by level, so its rise strobe and the data
    // pin edges have no consumer.
    assign w_unused_edges = {w_ce_rise, w_sdio_rise, w_sdio_fall};

    spi_state_t  r_state, w_state_nxt;
    logic [3:0]  r_bitcnt;
    logic        r_hb16;
    logic [14:0] r_hdr;
    logic [15:0] r_addr;
    logic [6:0]  r_wsh;
    logic [7:0]  r_tx;
    logic        r_rd_drive;
    logic        r_wr_strobe, r_frame_err;
    logic [15:0] r_wr_addr;
    logic [7:0]  r_wr_data, r_host_data;
    logic [7:0]  r_bank [DEPTH];

    logic        w_commit, w_abort, w_hdr_done, w_hdr_rw, w_wr_ok, w_drive;
    logic [3:0]  w_hdr_last;
    logic [15:0] w_hdr_full, w_hdr_addr;
    logic [7:0]  w_wdata_full, w_rd_val, w_host_val;

    // Header and data bytes as they stand after including the current bit.
    assign w_hdr_full   = {r_hdr, w_sdio};
    assign w_wdata_full = {r_wsh, w_sdio};
    assign w_hdr_last   = hdr_last_bit(r_hb16);
    assign w_hdr_done   = w_sclk_rise && (r_bitcnt == w_hdr_last);
    assign w_hdr_rw     = r_hb16 ? w_hdr_full[15] : w_hdr_full[7];
    assign w_hdr_addr   = r_hb16 ? {1'b0, w_hdr_full[14:0]} : {9'd0, w_hdr_full[6:0]};
    assign w_wr_ok      = (r_addr < DEPTH16) && (r_addr != STATUS_ADDR);

    // Read value is taken combinationally from the bank so it can be loaded
    // into the tx shifter on the same clk the header completes.
    always_comb begin
        w_rd_val = 8'h00;
        if (w_hdr_addr == STATUS_ADDR) begin
            w_rd_val = status_in;
        end else if (w_hdr_addr < DEPTH16) begin
            w_rd_val = r_bank[w_hdr_addr[IDX_W-1:0]];
        end
    end

    always_comb begin
        w_host_val = 8'h00;
        if ({8'h00, host_addr} < DEPTH16) begin
            w_host_val = r_bank[host_addr[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Chip enable is checked before any sclk edge so it always wins.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ce_fall) w_state_nxt = S_HDR;
            end
            S_HDR: begin
                if (w_ce) begin
                    w_state_nxt = S_IDLE;
                    w_abort     = 1'b1;
                end else if (w_hdr_done) begin
                    w_state_nxt = (w_hdr_rw == SPI_RW_READ) ? S_RDATA : S_WDATA;
                end
            end
            S_WDATA: begin
                if (w_ce) begin
                    w_state_nxt = S_IDLE;
                    w_abort     = 1'b1;
                end else if (w_sclk_rise && (r_bitcnt == 4'd7)) begin
                    w_state_nxt = S_WAIT;
                    w_commit    = 1'b1;
                end
            end
            S_RDATA: begin
                if (w_ce) begin
                    w_state_nxt = S_IDLE;
                    w_abort     = 1'b1;
                end else if (w_sclk_fall && (r_bitcnt == 4'd7)) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_ce) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bitcnt    <= 4'd0;
            r_hb16      <= 1'b0;
            r_hdr       <= 15'd0;
            r_addr      <= 16'd0;
            r_wsh       <= 7'd0;
            r_tx        <= 8'd0;
            r_rd_drive  <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= 16'd0;
            r_wr_data   <= 8'd0;
            r_frame_err <= 1'b0;
            r_host_data <= 8'd0;
        end else begin
            r_wr_strobe <= w_commit;
            r_frame_err <= w_abort;
            r_host_data <= w_host_val;
            if (w_commit) begin
                r_wr_addr <= r_addr;
                r_wr_data <= w_wdata_full;
            end
            case (r_state)
                S_IDLE: begin
                    r_rd_drive <= 1'b0;
                    if (w_ce_fall) begin
                        r_bitcnt <= 4'd0;
                        r_hb16   <= addr_2byte;
                    end
                end
                S_HDR: begin
                    if (!w_ce && w_sclk_rise) begin
                        r_hdr <= w_hdr_full[14:0];
                        if (w_hdr_done) begin
                            r_bitcnt <= 4'd0;
                            r_addr   <= w_hdr_addr;
                            r_tx     <= w_rd_val;
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end
                end
                S_WDATA: begin
                    if (!w_ce && w_sclk_rise) begin
                        r_wsh    <= w_wdata_full[6:0];
                        r_bitcnt <= r_bitcnt + 4'd1;
                    end
                end
                S_RDATA: begin
                    // First fall only enables the driver (MSB already
                    // sits in r_tx[7]); later falls shift the next bit up.
                    if (!w_ce && w_sclk_fall) begin
                        if (r_bitcnt == 4'd0) begin
                            r_rd_drive <= 1'b1;
                        end else begin
                            r_tx <= {r_tx[6:0], 1'b0};
                        end
                        r_bitcnt <= r_bitcnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_bank[i] <= RST_VAL;
        end else if (w_commit && w_wr_ok) begin
            r_bank[r_addr[IDX_W-1:0]] <= w_wdata_full;
        end
    end

    // Gating with the synchronised chip enable releases the pin one clk
    // before the FSM itself reaches S_IDLE.
    assign w_drive  = r_rd_drive && !w_ce &&
                      ((r_state == S_RDATA) || (r_state == S_WAIT));
    assign spi_sdio = (w_drive && three_wire)  ? r_tx[7] : 1'bz;
    assign spi_sdo  = (w_drive && !three_wire) ? r_tx[7] : 1'bz;

    assign host_data = r_host_data;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign frame_err = r_frame_err;

endmodule
